hc595_chain_tx: RTL
===================

// Module: hc595_chain_tx
// PURPOSE
//  Parametrised serial driver for a daisy-chain of N_CHIP 74HC595 shift/latch registers.
//  Accepts a W=8*N_CHIP-bit word over a valid/ready handshake and shifts it out on ds/shcp.
//  Latches the word with one stcp pulse and manages output-enable.
//  Sits between display/LED control logic and the board pins; replaces the fixed 16-bit driver.
// PARAMETERS
//  N_CHIP     2  number of chained 595s, legal 1..16; W = 8*N_CHIP
//  DIV_HALF   4  clk cycles per shcp half-period (H), legal >=1
//  MSB_FIRST  1  1: din[W-1] shifted first; 0: din[0] shifted first
// PORTS
//  clk      in   1  system clock
//  rst_n    in   1  asynchronous active-low reset
//  din      in   W  parallel word to load
//  din_vld  in   1  din valid
//  din_rdy  out  1  block idle, din accepted when din_vld && din_rdy
//  busy     out  1  transaction in progress (= !din_rdy)
//  done     out  1  one-cycle pulse, word latched to 595 outputs
//  shcp     out  1  595 shift clock, idles low
//  stcp     out  1  595 storage (latch) clock, idles low
//  ds       out  1  595 serial data
//  oe_n     out  1  595 output enable, active low
// BEHAVIOUR
//  Reset: din_rdy=1, busy=0, done=0, shcp=0, stcp=0, ds=0, oe_n=1; state=IDLE; all counters 0.
//  Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//  FSM: IDLE -> SHIFT on accept; SHIFT -> LATCH after bit W-1 high phase; LATCH -> IDLE after H cycles.
//  Accept at cycle t0: din copied to shift reg; din_rdy=0 from t0+1. din_vld while busy is ignored, not buffered.
//  SHIFT, bit k (k=0..W-1): shcp low cycles t0+1+2kH .. +H-1, high for next H cycles.
//  ds takes bit k on the first low cycle of bit k; it is stable through the shcp rising edge.
//  Bit order follows MSB_FIRST.
//  LATCH: stcp high cycles t0+1+2WH .. +H-1, shcp low, ds holds last bit.
//  IDLE entry at t0+1+2WH+H: stcp=0, done=1 for that cycle, din_rdy=1 that cycle.
//  An accept in that cycle starts the next word back-to-back. Accept-to-done latency = 1+(2W+1)*H cycles.
//  oe_n: 1 from reset until first done; 0 from the done cycle onward. The chip never shows power-up garbage.
//  ds returns to 0 in IDLE.
//  Counters:
//   - divider counts 0..H-1 and wraps; bit counter is $clog2(W)+1 bits, counts 0..W-1.
//   - No overflow at W=128 or H=1; with H=1, shcp toggles every clk.
//  Reset mid-transaction: immediate abort to reset values, partial word discarded.
//   - No stcp is issued; oe_n returns to 1.
//  stcp and shcp never high in the same cycle; exactly one stcp pulse per accepted word.
// STRUCTURE
//  Shared include hc595_defs.vh: FSM state encodings (IDLE/SHIFT/LATCH), W derivation macro.
//  Sub-module hc595_tick_gen: DIV_HALF divider; emits a phase-end tick and phase bit, cleared when idle.
//  The top holds the FSM, shift register, bit counter and oe_n flag.
// TESTING
//  N_CHIP=2,H=2, din=16'hA5C3: ds sampled at 16 shcp rises = A5C3 MSB first; one stcp; done at t0+67.
//  MSB_FIRST=0, din=16'h0001: first sampled bit 1, remaining 15 bits 0.
//  oe_n=1 after reset; falls with first done; stays 0 across second word.
//  Accept in the done cycle: next word's shcp low phase starts next cycle, no idle gap.
//  din_vld held high during SHIFT with different data: ignored; latched word = first din.
//  rst_n low at bit 7: all outputs at reset values, no stcp.
//   - After release, a new word 16'hFFFF shifts cleanly.
//  N_CHIP=1,H=1 and N_CHIP=16,H=3: bit count 8/128; latency 1+17 / 1+771 cycles.

Source files
------------

// File: rtl/hc595_chain_tx_pkg.sv
// Shared types and width helpers for the 74HC595 chain driver.
package hc595_chain_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    function automatic int word_w(input int n_chip);
        return 8 * n_chip;
    endfunction

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hc595_chain_tx_if.sv
// Word handshake between the display/LED control logic and the 595 chain driver.
interface hc595_chain_tx_if #(
    parameter int W = 16
);
    logic [W-1:0] din;
    logic         din_vld;
    logic         din_rdy;
    logic         busy;
    logic         done;

    modport master (output din, output din_vld, input din_rdy, input busy, input done);
    modport slave  (input din, input din_vld, output din_rdy, output busy, output done);
endinterface

// File: rtl/hc595_chain_tx_tick_gen.sv
// Half-period divider for shcp: pulses tick on the last clk of each phase and
// toggles phase; both held cleared while the driver is idle.
module hc595_chain_tx_tick_gen
    import hc595_chain_tx_pkg::*;
#(
    parameter int DIV_HALF = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick,
    output logic phase
);
    localparam int DW = cnt_w(DIV_HALF);

    logic [DW-1:0] div;

    assign tick = en && (div == DW'(DIV_HALF - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            div   <= '0;
            phase <= 1'b0;
        end else begin
            div <= tick ? '0 : div + DW'(1);
            if (tick) begin
                phase <= !phase;
            end
        end
    end

endmodule

// File: rtl/hc595_chain_tx.sv
// Serial driver for a daisy chain of N_CHIP 74HC595s: shifts a W-bit word out
// on ds/shcp, latches it with a single stcp pulse and manages oe_n.
module hc595_chain_tx
    import hc595_chain_tx_pkg::*;
#(
    parameter int N_CHIP    = 2,
    parameter int DIV_HALF  = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    hc595_chain_tx_if.slave bus,
    output logic            shcp,
    output logic            stcp,
    output logic            ds,
    output logic            oe_n
);
    localparam int W  = word_w(N_CHIP);
    localparam int BW = $clog2(W) + 1;

    state_t        state;
    state_t        state_nxt;
    logic          run;
    logic          tick;
    logic          phase;
    logic          accept;
    logic          bit_end;
    logic          last_bit;
    logic          latch_end;
    logic [BW-1:0] bit_cnt;
    logic [W-1:0]  din_ord;
    logic [W-1:0]  shreg;
    logic          done_q;
    logic          oe_n_q;

    hc595_chain_tx_tick_gen #(
        .DIV_HALF(DIV_HALF)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .tick  (tick),
        .phase (phase)
    );

    assign run       = (state != ST_IDLE);
    assign accept    = bus.din_vld && bus.din_rdy;
    assign bit_end   = (state == ST_SHIFT) && tick && phase;
    assign last_bit  = (bit_cnt == BW'(W - 1));
    assign latch_end = (state == ST_LATCH) && tick;

    // The shift register always sends its top bit first, so LSB-first words are
    // mirrored on load.
    always_comb begin
        din_ord = bus.din;
        if (!MSB_FIRST) begin
            for (int i = 0; i < W; i++) begin
                din_ord[i] = bus.din[W-1-i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.din_rdy = 1'b0;
        shcp        = 1'b0;
        stcp        = 1'b0;
        ds          = 1'b0;
        unique case (state)
            ST_IDLE: begin
                bus.din_rdy = 1'b1;
                if (bus.din_vld) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shcp = phase;
                ds   = shreg[W-1];
                if (bit_end && last_bit) begin
                    state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                stcp = 1'b1;
                ds   = shreg[W-1];
                if (tick) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The last bit is not shifted away so ds keeps it through the latch phase.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= din_ord;
        end else if (bit_end && !last_bit) begin
            shreg <= {shreg[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (!run) begin
            bit_cnt <= '0;
        end else if (bit_end && !last_bit) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Outputs stay disabled until a complete word has been latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            oe_n_q <= 1'b1;
        end else begin
            done_q <= latch_end;
            if (latch_end) begin
                oe_n_q <= 1'b0;
            end
        end
    end

    assign bus.busy = !bus.din_rdy;
    assign bus.done = done_q;
    assign oe_n     = oe_n_q;

endmodule
